match_ctrl: RTL and testbench

Round/match controller downstream of the two-player fighting-game core. It consumes the core's HP1/HP2 health outputs, detects KO and round timeout, and tallies rounds won. It drives the core's reset (GAME_RST) between rounds and reports match progress and winner to the display/top level.

---
 rtl/match_pkg.sv | 12 +
 rtl/round_timer.sv | 19 +
 rtl/match_ctrl.sv | 104 ++++++++++
 tb/tb_match_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// match_pkg: shared state encoding, round-result codes and helpers for the match controller.
package match_pkg;
   typedef enum logic [2:0] {IDLE, ARM, FIGHT, ROUND_END, MATCH_OVER} state_t;
   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_P1   = 2'b01;
   localparam logic [1:0] RES_P2   = 2'b10;
   localparam logic [1:0] RES_DRAW = 2'b11;
   localparam logic [1:0] HP_KO    = 2'd0;
   function automatic logic [1:0] cmp_res(input logic [1:0] a, input logic [1:0] b);
      return a > b ? RES_P1 : b > a ? RES_P2 : RES_DRAW;
   endfunction
endpackage

// File: rtl/round_timer.sv
// round_timer: loadable down-counter with hold; expire flags count==1.
module round_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic         hold,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         expire
);
   always_ff @(posedge clk)
      if (rst) count <= '0;
      else if (load) count <= load_val;
      else if (en && !hold && count != '0) count <= count - 1'b1;
   assign expire = count == W'(1);
endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: round/match controller (KO, timeout, win tally, core reset); MATCH_CTRL_SUDDEN_DEATH_EN adds sudden-death rounds.
module match_ctrl #(
   parameter int WINS_NEEDED  = 2,
   parameter int MAX_ROUNDS   = 5,
   parameter int ROUND_CYCLES = 64,
   parameter int PAUSE_CYCLES = 4,
   parameter int RST_HOLD     = 2,
   localparam int TW = $clog2(ROUND_CYCLES + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic [1:0]    HP1,
   input  logic [1:0]    HP2,
   output logic          GAME_RST,
   output logic          ROUND_ACTIVE,
   output logic [2:0]    ROUND,
   output logic [TW-1:0] TIMER,
   output logic [1:0]    P1_WINS,
   output logic [1:0]    P2_WINS,
   output logic [1:0]    ROUND_RESULT,
   output logic          MATCH_OVER,
   output logic [1:0]    WINNER
);
   import match_pkg::*;
   localparam int AW = $clog2(RST_HOLD + 1);
   localparam int PW = $clog2(PAUSE_CYCLES + 1);
   localparam logic [1:0] WN = 2'(WINS_NEEDED);
   localparam logic [2:0] MR = 3'(MAX_ROUNDS);
   state_t state, state_nxt;
   logic [1:0] fight_res;
   logic t_exp, arm_exp, pause_exp, match_done, go_sd, sd, start_ok;
   logic [AW-1:0] arm_cnt;
   logic [PW-1:0] pause_cnt;
   round_timer #(.W(TW)) u_fight (
      .clk(CLK), .rst(RST), .load(state == ARM && arm_exp), .en(state == FIGHT && fight_res == RES_NONE),
      .hold(sd), .load_val(TW'(ROUND_CYCLES)), .count(TIMER), .expire(t_exp)
   );
   round_timer #(.W(AW)) u_arm (
      .clk(CLK), .rst(RST), .load(state_nxt == ARM && state != ARM), .en(state == ARM),
      .hold(1'b0), .load_val(AW'(RST_HOLD)), .count(arm_cnt), .expire(arm_exp)
   );
   round_timer #(.W(PW)) u_pause (
      .clk(CLK), .rst(RST), .load(state == FIGHT && state_nxt == ROUND_END), .en(state == ROUND_END),
      .hold(1'b0), .load_val(PW'(PAUSE_CYCLES)), .count(pause_cnt), .expire(pause_exp)
   );
   // KO outranks timeout; timeout is suppressed during sudden death
   assign fight_res = (HP1 == HP_KO && HP2 == HP_KO) ? RES_DRAW :
                      HP1 == HP_KO ? RES_P2 :
                      HP2 == HP_KO ? RES_P1 :
                      (t_exp && !sd) ? cmp_res(HP1, HP2) : RES_NONE;
   assign match_done = P1_WINS == WN || P2_WINS == WN || ROUND >= MR;
`ifdef MATCH_CTRL_SUDDEN_DEATH_EN
   assign go_sd = ROUND >= MR && P1_WINS == P2_WINS;
`else
   assign go_sd = 1'b0;
`endif
   assign start_ok = (state == IDLE || state == match_pkg::MATCH_OVER) && START;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, match_pkg::MATCH_OVER: state_nxt = START ? ARM : state;
         ARM:       state_nxt = arm_exp ? FIGHT : ARM;
         FIGHT:     state_nxt = fight_res != RES_NONE ? ROUND_END : FIGHT;
         ROUND_END: state_nxt = !pause_exp ? ROUND_END : (match_done && !go_sd) ? match_pkg::MATCH_OVER : ARM;
         default:   state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge CLK)
      if (RST) begin
         state        <= IDLE;
         ROUND        <= '0;
         P1_WINS      <= '0;
         P2_WINS      <= '0;
         ROUND_RESULT <= RES_NONE;
         WINNER       <= RES_NONE;
         sd           <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start_ok) begin
            ROUND        <= 3'd1;
            P1_WINS      <= '0;
            P2_WINS      <= '0;
            ROUND_RESULT <= RES_NONE;
            WINNER       <= RES_NONE;
            sd           <= 1'b0;
         end
         if (state == FIGHT && fight_res != RES_NONE) begin
            ROUND_RESULT <= fight_res;
            P1_WINS      <= P1_WINS + {1'b0, fight_res == RES_P1 && P1_WINS != 2'd3};
            P2_WINS      <= P2_WINS + {1'b0, fight_res == RES_P2 && P2_WINS != 2'd3};
         end
         if (state == ROUND_END && pause_exp) begin
            if (match_done && !go_sd) WINNER <= cmp_res(P1_WINS, P2_WINS);
            else begin
               ROUND <= ROUND == 3'd7 ? ROUND : ROUND + 3'd1;
               sd    <= go_sd;
            end
         end
      end
   assign GAME_RST     = state != FIGHT;
   assign ROUND_ACTIVE = state == FIGHT;
   assign MATCH_OVER   = state == match_pkg::MATCH_OVER;
endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: directed + random stimulus against a cycle-level behavioural model of the match rules.
module tb_match_ctrl;
   localparam int WN = 2, MR = 5, RC = 64, PC = 4, RH = 2;
   localparam int TW = $clog2(RC + 1);
   localparam int P_IDLE = 0, P_ARM = 1, P_FIGHT = 2, P_END = 3, P_OVER = 4;
   logic CLK = 1'b0, RST = 1'b1, START = 1'b0;
   logic [1:0] HP1 = 2'd3, HP2 = 2'd3;
   logic GAME_RST, ROUND_ACTIVE, MATCH_OVER;
   logic [2:0] ROUND;
   logic [TW-1:0] TIMER;
   logic [1:0] P1_WINS, P2_WINS, ROUND_RESULT, WINNER;
   int checks = 0, failures = 0;
   bit chk_on = 1'b0;
   int m_phase, m_left, m_round, m_timer, m_w1, m_w2, m_res, m_win;
   bit m_sd;
   int n;

   match_ctrl #(.WINS_NEEDED(WN), .MAX_ROUNDS(MR), .ROUND_CYCLES(RC), .PAUSE_CYCLES(PC), .RST_HOLD(RH)) dut (
      .CLK(CLK), .RST(RST), .START(START), .HP1(HP1), .HP2(HP2), .GAME_RST(GAME_RST),
      .ROUND_ACTIVE(ROUND_ACTIVE), .ROUND(ROUND), .TIMER(TIMER), .P1_WINS(P1_WINS), .P2_WINS(P2_WINS),
      .ROUND_RESULT(ROUND_RESULT), .MATCH_OVER(MATCH_OVER), .WINNER(WINNER)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
      end
   endtask

   function automatic int pick(input int a, input int b);
      return a > b ? 1 : b > a ? 2 : 3;
   endfunction

   function automatic int outcome();
      if (HP1 == 0 && HP2 == 0) return 3;
      if (HP1 == 0) return 2;
      if (HP2 == 0) return 1;
      if (m_timer == 1 && !m_sd) return pick(int'(HP1), int'(HP2));
      return 0;
   endfunction

   task automatic begin_arm();
      m_phase = P_ARM;
      m_left  = RH;
   endtask

   task automatic model_step();
      int r;
      bit over, sd_ok;
      if (RST) begin
         m_phase = P_IDLE; m_left = 0; m_round = 0; m_timer = 0;
         m_w1 = 0; m_w2 = 0; m_res = 0; m_win = 0; m_sd = 0;
      end else if (m_phase == P_IDLE || m_phase == P_OVER) begin
         if (START) begin
            begin_arm();
            m_round = 1; m_w1 = 0; m_w2 = 0; m_res = 0; m_win = 0; m_sd = 0;
         end
      end else if (m_phase == P_ARM) begin
         m_left--;
         if (m_left == 0) begin
            m_phase = P_FIGHT;
            m_timer = RC;
         end
      end else if (m_phase == P_FIGHT) begin
         r = outcome();
         if (r != 0) begin
            m_res = r;
            if (r == 1 && m_w1 < 3) m_w1++;
            if (r == 2 && m_w2 < 3) m_w2++;
            m_phase = P_END;
            m_left  = PC;
         end else if (!m_sd) m_timer--;
      end else begin
         m_left--;
         if (m_left == 0) begin
            over = m_w1 == WN || m_w2 == WN || m_round >= MR;
`ifdef MATCH_CTRL_SUDDEN_DEATH_EN
            sd_ok = m_round >= MR && m_w1 == m_w2;
`else
            sd_ok = 1'b0;
`endif
            if (over && !sd_ok) begin
               m_phase = P_OVER;
               m_win   = pick(m_w1, m_w2);
            end else begin
               begin_arm();
               m_sd    = sd_ok;
               m_round = m_round < 7 ? m_round + 1 : 7;
            end
         end
      end
   endtask

   always @(posedge CLK) model_step();

   always @(negedge CLK)
      if (chk_on) begin
         chk("game_rst", GAME_RST, m_phase != P_FIGHT);
         chk("round_active", ROUND_ACTIVE, m_phase == P_FIGHT);
         chk("match_over", MATCH_OVER, m_phase == P_OVER);
         chk("round", ROUND, m_round);
         chk("timer", TIMER, m_timer);
         chk("p1_wins", P1_WINS, m_w1);
         chk("p2_wins", P2_WINS, m_w2);
         chk("round_result", ROUND_RESULT, m_res);
         chk("winner", WINNER, m_win);
      end

   task automatic wait_active(input logic v, output int cnt);
      cnt = 0;
      while (ROUND_ACTIVE !== v && cnt < 300) begin
         @(negedge CLK);
         cnt++;
      end
      if (ROUND_ACTIVE !== v) chk("wait_active_timeout", ROUND_ACTIVE, v);
   endtask

   task automatic wait_over();
      int c = 0;
      while (MATCH_OVER !== 1'b1 && c < 300) begin
         @(negedge CLK);
         c++;
      end
      if (MATCH_OVER !== 1'b1) chk("wait_over_timeout", MATCH_OVER, 1);
   endtask

   task automatic pulse_start();
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      chk_on = 1'b1;
      chk("rst_game_rst", GAME_RST, 1);
      chk("rst_round", ROUND, 0);
      chk("rst_timer", TIMER, 0);
      RST = 1'b0;
      // round 1: P2 knocked out on FIGHT cycle 5
      pulse_start();
      chk("arm_round", ROUND, 1);
      wait_active(1'b1, n);
      repeat (4) @(negedge CLK);
      HP2 = 2'd0;
      @(negedge CLK);
      chk("ko_result", ROUND_RESULT, 2'b01);
      chk("ko_p1_wins", P1_WINS, 1);
      chk("ko_timer", TIMER, RC - 4);
      HP2 = 2'd3;
      wait_active(1'b1, n);
      chk("rst_gap", n, PC + RH);
      chk("round2", ROUND, 2);
      HP2 = 2'd0;
      @(negedge CLK);
      chk("p1_two_wins", P1_WINS, 2);
      HP2 = 2'd3;
      wait_over();
      chk("winner_p1", WINNER, 2'b01);
      chk("over_round", ROUND, 2);
      chk("over_game_rst", GAME_RST, 1);
      // timeouts: decisive, then even, then KO on the final timer cycle
      HP1 = 2'd2; HP2 = 2'd1;
      pulse_start();
      chk("restart_wins", P1_WINS, 0);
      chk("restart_round", ROUND, 1);
      wait_active(1'b1, n);
      wait_active(1'b0, n);
      chk("timeout_p1", ROUND_RESULT, 2'b01);
      HP1 = 2'd2; HP2 = 2'd2;
      wait_active(1'b1, n);
      wait_active(1'b0, n);
      chk("timeout_draw", ROUND_RESULT, 2'b11);
      chk("draw_p1_wins", P1_WINS, 1);
      chk("draw_p2_wins", P2_WINS, 0);
      HP1 = 2'd1; HP2 = 2'd2;
      wait_active(1'b1, n);
      n = 0;
      while (TIMER !== TW'(1) && n < 300) begin
         @(negedge CLK);
         n++;
      end
      chk("timer_one", TIMER, 1);
      HP2 = 2'd0;
      @(negedge CLK);
      chk("ko_beats_timeout", ROUND_RESULT, 2'b01);
      HP1 = 2'd3; HP2 = 2'd3;
      wait_over();
      chk("winner_p1_b", WINNER, 2'b01);
      // five double-KO rounds
      pulse_start();
      for (int r = 0; r < MR; r++) begin
         wait_active(1'b1, n);
         HP1 = 2'd0; HP2 = 2'd0;
         @(negedge CLK);
         chk("double_ko", ROUND_RESULT, 2'b11);
         HP1 = 2'd3; HP2 = 2'd3;
      end
`ifdef MATCH_CTRL_SUDDEN_DEATH_EN
      wait_active(1'b1, n);
      chk("sd_round", ROUND, 6);
      repeat (10) @(negedge CLK);
      chk("sd_timer_frozen", TIMER, RC);
      HP1 = 2'd0;
      @(negedge CLK);
      HP1 = 2'd3;
      wait_over();
      chk("sd_winner", WINNER, 2'b10);
`else
      wait_over();
      chk("draw_winner", WINNER, 2'b11);
      chk("draw_round", ROUND, MR);
`endif
      // reset in the middle of round 2, START ignored while fighting
      HP2 = 2'd0;
      pulse_start();
      wait_active(1'b1, n);
      @(negedge CLK);
      HP2 = 2'd3;
      wait_active(1'b1, n);
      START = 1'b1;
      repeat (3) @(negedge CLK);
      chk("start_ignored", ROUND_ACTIVE, 1);
      chk("mid_round", ROUND, 2);
      chk("mid_p1_wins", P1_WINS, 1);
      START = 1'b0;
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("midrst_round", ROUND, 0);
      chk("midrst_game_rst", GAME_RST, 1);
      chk("midrst_active", ROUND_ACTIVE, 0);
      chk("midrst_wins", P1_WINS, 0);
      chk("midrst_timer", TIMER, 0);
      // random traffic
      for (int i = 0; i < 5000; i++) begin
         @(negedge CLK);
         RST   = $urandom_range(0, 399) == 0;
         START = $urandom_range(0, 7) == 0;
         HP1   = $urandom_range(0, 15) == 0 ? 2'd0 : 2'($urandom_range(1, 3));
         HP2   = $urandom_range(0, 15) == 0 ? 2'd0 : 2'($urandom_range(1, 3));
      end
      RST = 1'b0; START = 1'b0;
      repeat (3) @(negedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
